// File: rtl/picorv32_bram_responder.sv
// Responder between the picorv32 native memory bus and one byte-writable BRAM port.
// Define BRAM_OUTREG_EN when the BRAM output register is enabled; this adds one read wait state.
module picorv32_bram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_BITS = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        hit,
  output logic [15:0] bram_ad,
  output logic [31:0] bram_di,
  output logic [3:0]  bram_wre,
  output logic        bram_sel,
  input  logic [31:0] bram_do
);

  localparam logic [31:0] WIN_MASK = (32'd1 << ADDR_BITS) - 32'd1;
  localparam logic [31:0] HI_MASK  = ~WIN_MASK;
  localparam logic [15:0] AD_MASK  = WIN_MASK[15:0];

`ifdef BRAM_OUTREG_EN
  typedef enum logic [2:0] {IDLE, ACCESS, RD_WAIT, RD_DATA, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACCESS, RD_DATA, RESP} state_t;
`endif

  state_t state_q, state_d;
  logic   wr_q;

  // Handshake: a request is taken when mem_valid is high on an IDLE edge and the
  // address decodes; mem_ready answers it with exactly one high cycle. mem_valid is
  // never sampled outside IDLE, so a request held across RESP is not taken twice.
  logic unused_instr;
  assign unused_instr = mem_instr;

  assign hit = mem_valid && (((mem_addr ^ BASE_ADDR) & HI_MASK) == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACCESS;
`ifdef BRAM_OUTREG_EN
      ACCESS:  state_d = wr_q ? RESP : RD_WAIT;
      RD_WAIT: state_d = RD_DATA;
`else
      ACCESS:  state_d = wr_q ? RESP : RD_DATA;
`endif
      RD_DATA: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      bram_ad   <= 16'd0;
      bram_di   <= 32'd0;
      bram_wre  <= 4'd0;
      bram_sel  <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            bram_ad  <= mem_addr[15:0] & AD_MASK;
            bram_di  <= mem_wdata;
            bram_wre <= mem_wstrb;
            bram_sel <= 1'b1;
            wr_q     <= |mem_wstrb;
          end
        end
        ACCESS: begin
          // The BRAM samples the port on this edge; select and strobes become one-cycle pulses.
          bram_sel <= 1'b0;
          bram_wre <= 4'd0;
          if (wr_q) mem_ready <= 1'b1;
        end
        RD_DATA: begin
          mem_rdata <= bram_do;
          mem_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/picorv32_bram_responder.md
Name: picorv32_bram_responder

Overview:
- Bus-side responder that sits between the picorv32 native memory interface and one 2048x32 byte-writable BRAM port.
- Decodes an address window, drives the BRAM port address, data, byte-enables and select from registers, and captures read data.
- Returns a single-cycle `mem_ready` pulse per transaction.
- One instance per BRAM port; the instruction/data arbitration lives upstream.

Parameters:
- BASE_ADDR, 32'h0000_0000, window base; bits [ADDR_BITS-1:0] are ignored.
- ADDR_BITS, 13, window size is 2^ADDR_BITS bytes; legal range 13..16 (16 covers all 8 block-select banks).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  CPU request valid
- mem_instr  in  1  instruction fetch flag; ignored except by `hit` logic (none)
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 means read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data; valid while `mem_ready`=1
- hit  out  1  combinational: `mem_valid` & address in window
- bram_ad  out  16  BRAM byte address (port uses [15:2], [15:13] = block select)
- bram_di  out  32  BRAM write data
- bram_wre  out  4  BRAM per-byte write enables
- bram_sel  out  1  BRAM port select/enable
- bram_do  in  32  BRAM read data, valid one clock after the sampling edge

Behaviour:
- Decode: `hit` = `mem_valid` && `mem_addr[31:ADDR_BITS]` == `BASE_ADDR[31:ADDR_BITS]`.
- `bram_ad` register captures `mem_addr[15:0]`, with bits at and above ADDR_BITS forced to 0.
- Reset (async): state=IDLE; `mem_ready`=0, `mem_rdata`=0, `bram_ad`=0, `bram_di`=0, `bram_wre`=0, `bram_sel`=0.
- FSM states: IDLE, ACCESS, RD_DATA, RESP.
- IDLE:
  - On an edge with `hit`=1, register `bram_ad`, `bram_di`=`mem_wdata`, `bram_wre`=`mem_wstrb`, `bram_sel`=1; go to ACCESS.
  - Requests with `hit`=0 are ignored and never acknowledged.
- ACCESS (BRAM samples on this edge):
  - Clear `bram_sel` and `bram_wre` to 0; `bram_ad`/`bram_di` hold.
  - Write (captured wstrb != 0): set `mem_ready`=1, go to RESP.
  - Read: go to RD_DATA.
- RD_DATA: `mem_rdata` <= `bram_do`; `mem_ready` <= 1; go to RESP.
- RESP: `mem_ready` <= 0; go to IDLE. `mem_valid` is not sampled in RESP, which prevents the same request being serviced twice.
- Latency, with request sampled at edge N:
  - Write: `mem_ready` high in the cycle following edge N+1.
  - Read: `mem_ready` high in the cycle following edge N+2.
- Minimum spacing between accepted requests: 3 cycles (write), 4 cycles (read).
- `mem_ready` is never high for more than one cycle.
- `mem_rdata` holds its last read value across writes and idle periods.
- `bram_sel` and any nonzero `bram_wre` are exactly one-cycle pulses per transaction.
- Partial strobes (e.g. 4'b0100) pass through unchanged; no read-modify-write.
- `mem_valid` dropping mid-transaction (protocol violation): the transaction completes anyway, including the `mem_ready` pulse.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. An aborted write may or may not have reached the BRAM (undefined); no `mem_ready` is issued.
- Address wrap: the window is not checked for overflow; the top of the window is contiguous with no special case.

Optional Feature:
- Macro: BRAM_OUTREG_EN.
- Defined: the BRAM is configured with an output register (bypass off).
  - Adds state RD_WAIT between ACCESS and RD_DATA; `bram_do` is sampled one edge later.
  - Read latency becomes N+3; write timing is unchanged.
- Undefined: FSM exactly as above; RD_WAIT does not exist.

Test Plan:
- Reset, then word write: `mem_addr`=0x0000_0010, `mem_wdata`=0xDEADBEEF, `mem_wstrb`=4'hF.
  -> `bram_ad`=0x0010, `bram_wre`=4'hF and `bram_sel`=1 for exactly one cycle; one `mem_ready` pulse 2 edges after the request.
- Read back 0x10 (BRAM model returns stored data).
  -> `mem_rdata`=0xDEADBEEF with `mem_ready` pulse 3 edges after the request (4 with BRAM_OUTREG_EN).
- Byte write `mem_wstrb`=4'b0100, `mem_wdata`=0x00AA0000 to 0x10, then read.
  -> `bram_wre`=4'b0100; readback 0xDEAABEEF.
- Out-of-window access with BASE_ADDR=0x0001_0000: request 0x0000_0010.
  -> `hit`=0, `bram_sel` never asserted, `mem_ready` stays 0 for 10 cycles.
- Back-to-back: `mem_valid` held high across RESP with a second read queued.
  -> exactly one `mem_ready` per transaction; second access starts in IDLE, never in RESP.
- Assert `rst` in RD_DATA.
  -> `mem_ready`=0 and all `bram_*` outputs 0 immediately; next request is serviced normally.
